comm_tx_arbiter: RTL and testbench
==================================

// Module: comm_tx_arbiter
// PURPOSE
//  Shares the single comm_transmitter between two response sources: req0 = comm_process
//  response path, req1 = auxiliary source (e.g. time-cal / test pattern).
//  Grants per packet, holds the grant until the transmitter finishes, then enforces a quiet gap.
//  Sits between the sources and comm_transmitter.transmitter_on/rspns/rspns_read/tx_machine_on.
// PARAMETERS
//  GAP_CYCLES     64    inclk cycles of line quiet after tx_machine_on falls; 0 = no gap
//  START_TIMEOUT  1024  max cycles in ACTIVE without tx_machine_on rising before abort
//  CNT_W          16    width of gap/timeout counter; must hold max(GAP_CYCLES, START_TIMEOUT)
// PORTS
//  inclk          in   1   system clock (20 MHz)
//  reset          in   1   asynchronous, active-high reset
//  req0_on        in   1   source 0 requests transmitter (transmitter_on semantics)
//  req0_word      in   32  source 0 current response word
//  req0_read      out  1   word-consumed strobe to source 0
//  req1_on        in   1   source 1 request
//  req1_word      in   32  source 1 current response word
//  req1_read      out  1   word-consumed strobe to source 1
//  tx_on          out  1   to comm_transmitter.transmitter_on
//  tx_word        out  32  to comm_transmitter.rspns
//  tx_read        in   1   from comm_transmitter.rspns_read
//  tx_machine_on  in   1   from comm_transmitter: high while DAC sequencing a packet
//  grant          out  2   one-hot owner: 01 = src0, 10 = src1, 00 = none
//  busy           out  1   high in any state other than IDLE
//  timeout_err    out  1   one-cycle pulse on start-timeout abort
// BEHAVIOUR
//  - Reset (async, immediate): state = IDLE; tx_on, grant, busy, timeout_err = 0; counter = 0.
//  - tx_word = granted reqN_word; 32'h0 when grant == 00 (combinational mux).
//  - reqN_read = tx_read & grant[N] (combinational); tx_read with grant == 00 is ignored.
//  - IDLE: if any reqN_on, register grant and assert tx_on on the next edge; go to ACTIVE.
//    The request-to-tx_on latency is 1 cycle.
//  - ACTIVE: tx_on = 1.
//    - Granted req_on low -> drop tx_on, go to DRAIN. This is checked first, including on the
//      first ACTIVE cycle.
//    - tx_machine_on not yet seen high after START_TIMEOUT cycles -> pulse timeout_err,
//      drop tx_on, clear grant, go to GAP.
//  - DRAIN: tx_on = 0, grant held because the transmitter may still read words.
//    tx_machine_on == 0 and was seen high (or aborted) -> clear grant, go to GAP.
//    If tx_machine_on was never seen high, DRAIN exits on the same timeout.
//  - GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES = 0, GAP lasts exactly
//    1 cycle. New requests are ignored, not latched, until IDLE.
//  - Non-granted requester is never read and never preempts an open grant.
//  - Counter saturates at all-ones and never wraps. Counter is cleared on every state entry.
//  - Reset mid-packet drops tx_on the same instant; comm_transmitter must abort.
// CONFIGURATION
//  COMM_TX_RR_EN defined:
//    round-robin. On simultaneous req0_on & req1_on in IDLE, grant goes to the source not
//    served last. last_owner resets to src1, so src0 wins the first tie.
//  COMM_TX_RR_EN undefined:
//    fixed priority. On a tie src0 always wins; last_owner logic is not built.
// STRUCTURE
//  - comm_tx_pkg (shared package):
//    - state localparams S_IDLE = 3'd0, S_ACTIVE = 3'd1, S_DRAIN = 3'd2, S_GAP = 3'd3
//    - GRANT_NONE / GRANT_0 / GRANT_1
//  - One sub-module: comm_tx_gap_timer.
//    - inclk, reset, clr, en, limit[CNT_W-1:0] -> done, saturating
//    - shared between the GAP count and the start timeout
// TESTING
//  1. req0_on = 1 alone -> grant = 01 and tx_on = 1 one cycle later.
//     Pulse tx_read x4 with req0_word = 32'h0102_8000 -> req0_read pulses x4, req1_read = 0.
//  2. req0_on = req1_on = 1 in the same cycle, twice back-to-back:
//     - RR_EN: grants go 01 then 10
//     - without RR_EN: grants go 01 then 01
//  3. Hold tx_machine_on = 1 for 500 cycles after req0_on drops -> tx_on = 0, grant = 01
//     throughout DRAIN. tx_machine_on falls -> grant = 00 and exactly 64 GAP cycles pass
//     before the next grant.
//  4. req1_on = 1 with tx_machine_on held 0 -> timeout_err pulses at cycle 1024 of ACTIVE,
//     tx_on = 0, then GAP, then IDLE.
//  5. Assert reset mid-ACTIVE -> tx_on, grant, busy = 0 asynchronously (before the next edge);
//     request after release -> normal 1-cycle grant.
//  6. req1_on pulses while in GAP with GAP_CYCLES = 0 -> no grant.
//     req1_on held through GAP -> granted 1 cycle after IDLE.

Source files
------------

// File: rtl/comm_tx_pkg.sv
// comm_tx_pkg
//   Shared types and constants for the comm_tx_arbiter slice.
//   - state_t   : arbiter FSM encoding (S_IDLE/S_ACTIVE/S_DRAIN/S_GAP)
//   - GRANT_*   : one-hot owner codes driven on the grant output
//   - pick_grant: IDLE-state owner selection for a given tie preference
`timescale 1ns/1ps

package comm_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_DRAIN  = 3'd2,
        S_GAP    = 3'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

    // prefer1 only matters when both sources request in the same cycle.
    function automatic logic [1:0] pick_grant(input logic req0,
                                              input logic req1,
                                              input logic prefer1);
        if (req0 && req1)
            return prefer1 ? GRANT_1 : GRANT_0;
        else if (req0)
            return GRANT_0;
        else if (req1)
            return GRANT_1;
        else
            return GRANT_NONE;
    endfunction

endpackage

// File: rtl/comm_tx_gap_timer.sv
// comm_tx_gap_timer
//   Saturating up-counter shared by the arbiter for the post-packet quiet gap
//   and the start timeout. done is high during the limit-th enabled cycle after
//   clr (limit 0 behaves like 1, so a zero-length wait still costs one cycle).
// Ports
//   inclk  in   1      system clock
//   reset  in   1      asynchronous active-high reset
//   clr    in   1      synchronous clear, wins over en
//   en     in   1      count enable
//   limit  in   CNT_W  cycles to wait
//   done   out  1      limit reached (combinational)
`timescale 1ns/1ps

module comm_tx_gap_timer #(
    parameter int CNT_W = 16
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge inclk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + ONE;
    end

    // cnt holds cycles already elapsed, so the limit-th cycle sees limit-1.
    assign done = (limit == '0) || (cnt >= (limit - ONE));

endmodule

// File: rtl/comm_tx_arbiter.sv
// comm_tx_arbiter
//   Shares one comm_transmitter between two response sources. Grants per
//   packet, holds the grant until the transmitter has finished with the packet,
//   then keeps the line quiet for GAP_CYCLES before arbitrating again.
//   Build option: define COMM_TX_RR_EN for round-robin on ties; otherwise
//   source 0 has fixed priority.
// Ports
//   inclk          in   1   system clock
//   reset          in   1   asynchronous active-high reset
//   req0_on        in   1   source 0 transmit request
//   req0_word      in   32  source 0 response word
//   req0_read      out  1   word-consumed strobe to source 0
//   req1_on        in   1   source 1 transmit request
//   req1_word      in   32  source 1 response word
//   req1_read      out  1   word-consumed strobe to source 1
//   tx_on          out  1   transmitter_on to comm_transmitter
//   tx_word        out  32  rspns to comm_transmitter
//   tx_read        in   1   rspns_read from comm_transmitter
//   tx_machine_on  in   1   transmitter busy sequencing a packet
//   grant          out  2   one-hot owner (00 = none)
//   busy           out  1   FSM not idle
//   timeout_err    out  1   one-cycle pulse when a packet is abandoned
//
// state    | meaning
// S_IDLE   | no owner; first request seen is granted on the next edge
// S_ACTIVE | tx_on high, owner's words muxed to the transmitter
// S_DRAIN  | tx_on low, grant held while the transmitter finishes reading
// S_GAP    | no owner, line quiet; requests ignored
`timescale 1ns/1ps

module comm_tx_arbiter #(
    parameter int GAP_CYCLES    = 64,
    parameter int START_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic        inclk,
    input  logic        reset,
    input  logic        req0_on,
    input  logic [31:0] req0_word,
    output logic        req0_read,
    input  logic        req1_on,
    input  logic [31:0] req1_word,
    output logic        req1_read,
    output logic        tx_on,
    output logic [31:0] tx_word,
    input  logic        tx_read,
    input  logic        tx_machine_on,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err
);

    import comm_tx_pkg::*;

    localparam logic [CNT_W-1:0] GAP_LIMIT   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] START_LIMIT = CNT_W'(START_TIMEOUT);

    state_t           state, state_nxt;
    logic [1:0]       grant_q, grant_nxt;
    logic             timeout_q, timeout_nxt;
    logic             seen_q;
    logic             seen;
    logic             granted_on;
    logic             prefer1;
    logic             tmr_clr, tmr_en, tmr_done;
    logic [CNT_W-1:0] tmr_limit;

`ifdef COMM_TX_RR_EN
    // 1 = source 1 was served last; reset value lets source 0 win the first tie.
    logic last_owner;

    always_ff @(posedge inclk or posedge reset) begin
        if (reset)
            last_owner <= 1'b1;
        else if ((state == S_IDLE) && (grant_nxt != GRANT_NONE))
            last_owner <= grant_nxt[1];
    end

    assign prefer1 = ~last_owner;
`else
    assign prefer1 = 1'b0;
`endif

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            grant_q   <= GRANT_NONE;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Remembers that the transmitter actually started this packet, so DRAIN
    // can tell "finished" apart from "never began".
    always_ff @(posedge inclk or posedge reset) begin
        if (reset)
            seen_q <= 1'b0;
        else if (state == S_IDLE)
            seen_q <= 1'b0;
        else if (((state == S_ACTIVE) || (state == S_DRAIN)) && tx_machine_on)
            seen_q <= 1'b1;
    end

    assign seen       = seen_q | tx_machine_on;
    assign granted_on = (grant_q[0] & req0_on) | (grant_q[1] & req1_on);

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_q;
        timeout_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0_on || req1_on) begin
                    grant_nxt = pick_grant(req0_on, req1_on, prefer1);
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!granted_on) begin
                    state_nxt = S_DRAIN;
                end else if (!seen && tmr_done) begin
                    timeout_nxt = 1'b1;
                    grant_nxt   = GRANT_NONE;
                    state_nxt   = S_GAP;
                end
            end
            S_DRAIN: begin
                if (!tx_machine_on && seen_q) begin
                    grant_nxt = GRANT_NONE;
                    state_nxt = S_GAP;
                end else if (!seen && tmr_done) begin
                    // Transmitter never started: abandon the packet as in ACTIVE.
                    timeout_nxt = 1'b1;
                    grant_nxt   = GRANT_NONE;
                    state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_done)
                    state_nxt = S_IDLE;
            end
            default: begin
                grant_nxt = GRANT_NONE;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The counter restarts on every state change, so each state times itself.
    assign tmr_clr   = (state_nxt != state);
    assign tmr_en    = (state != S_IDLE);
    assign tmr_limit = (state == S_GAP) ? GAP_LIMIT : START_LIMIT;

    comm_tx_gap_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .inclk (inclk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_comb begin
        case (grant_q)
            GRANT_0: tx_word = req0_word;
            GRANT_1: tx_word = req1_word;
            default: tx_word = 32'h0;
        endcase
    end

    // Decoded straight from the state flop so reset removes tx_on immediately.
    assign tx_on       = (state == S_ACTIVE);
    assign busy        = (state != S_IDLE);
    assign grant       = grant_q;
    assign timeout_err = timeout_q;
    assign req0_read   = tx_read & grant_q[0];
    assign req1_read   = tx_read & grant_q[1];

endmodule

// File: tb/tb_comm_tx_arbiter.sv
`timescale 1ns/1ps

module tb_comm_tx_arbiter;

    logic        inclk = 1'b0;
    logic        reset;
    logic        req0_on, req1_on, tx_read, tx_machine_on;
    logic [31:0] req0_word, req1_word;

    logic        req0_read, req1_read, tx_on, busy, timeout_err;
    logic [31:0] tx_word;
    logic [1:0]  grant;

    logic        g0_req0_read, g0_req1_read, g0_tx_on, g0_busy, g0_timeout_err;
    logic [31:0] g0_tx_word;
    logic [1:0]  g0_grant;

    int checks   = 0;
    int failures = 0;

    always #25 inclk = ~inclk;

    comm_tx_arbiter #(.GAP_CYCLES(64), .START_TIMEOUT(1024), .CNT_W(16)) dut (
        .inclk(inclk), .reset(reset),
        .req0_on(req0_on), .req0_word(req0_word), .req0_read(req0_read),
        .req1_on(req1_on), .req1_word(req1_word), .req1_read(req1_read),
        .tx_on(tx_on), .tx_word(tx_word), .tx_read(tx_read),
        .tx_machine_on(tx_machine_on), .grant(grant), .busy(busy),
        .timeout_err(timeout_err)
    );

    comm_tx_arbiter #(.GAP_CYCLES(0), .START_TIMEOUT(1024), .CNT_W(16)) dut_g0 (
        .inclk(inclk), .reset(reset),
        .req0_on(req0_on), .req0_word(req0_word), .req0_read(g0_req0_read),
        .req1_on(req1_on), .req1_word(req1_word), .req1_read(g0_req1_read),
        .tx_on(g0_tx_on), .tx_word(g0_tx_word), .tx_read(tx_read),
        .tx_machine_on(tx_machine_on), .grant(g0_grant), .busy(g0_busy),
        .timeout_err(g0_timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ends the current packet: request dropped, transmitter runs one cycle,
    // then waits (bounded) for the arbiter to return to idle.
    task automatic finish_packet(input string tag);
        int n;
        req0_on = 1'b0;
        req1_on = 1'b0;
        tx_machine_on = 1'b1;
        @(negedge inclk);
        tx_machine_on = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge inclk);
            n++;
        end
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] exp_w;
        logic        ok, early;
        int          n, gap_n, idle_n, n_on;

        reset = 1'b1;
        req0_on = 1'b0; req1_on = 1'b0; tx_read = 1'b0; tx_machine_on = 1'b0;
        req0_word = 32'h0102_8000;
        req1_word = 32'hA5A5_0001;
        repeat (3) @(negedge inclk);

        // Reset state
        chk("rst_tx_on", {31'b0, tx_on}, 32'd0);
        chk("rst_grant", {30'b0, grant}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_timeout", {31'b0, timeout_err}, 32'd0);
        chk("rst_tx_word", tx_word, 32'h0);
        reset = 1'b0;
        @(negedge inclk);

        // tx_read with no owner is ignored
        tx_read = 1'b1;
        #1;
        chk("idle_read0", {31'b0, req0_read}, 32'd0);
        chk("idle_read1", {31'b0, req1_read}, 32'd0);
        tx_read = 1'b0;
        @(negedge inclk);

        // Ties, twice back-to-back
        req0_on = 1'b1; req1_on = 1'b1;
        @(negedge inclk);
        chk("tie1_grant", {30'b0, grant}, 32'd1);
        chk("tie1_tx_on", {31'b0, tx_on}, 32'd1);
        chk("tie1_word", tx_word, 32'h0102_8000);
        finish_packet("tie1");
        req0_on = 1'b1; req1_on = 1'b1;
        @(negedge inclk);
`ifdef COMM_TX_RR_EN
        exp_g = 2'b10; exp_w = 32'hA5A5_0001;
`else
        exp_g = 2'b01; exp_w = 32'h0102_8000;
`endif
        chk("tie2_grant", {30'b0, grant}, {30'b0, exp_g});
        chk("tie2_word", tx_word, exp_w);
        finish_packet("tie2");

        // Single request, one-cycle latency, four word reads
        req0_on = 1'b1;
        #1;
        chk("t1_pre_tx_on", {31'b0, tx_on}, 32'd0);
        @(negedge inclk);
        chk("t1_grant", {30'b0, grant}, 32'd1);
        chk("t1_tx_on", {31'b0, tx_on}, 32'd1);
        chk("t1_word", tx_word, 32'h0102_8000);
        tx_machine_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_read = 1'b1;
            #1;
            chk("t1_read0", {31'b0, req0_read}, 32'd1);
            chk("t1_read1", {31'b0, req1_read}, 32'd0);
            @(negedge inclk);
            tx_read = 1'b0;
            #1;
            chk("t1_read0_low", {31'b0, req0_read}, 32'd0);
            @(negedge inclk);
        end

        // DRAIN holds grant while the transmitter is busy, then a 64-cycle gap
        req0_on = 1'b0;
        @(negedge inclk);
        chk("t3_drain_tx_on", {31'b0, tx_on}, 32'd0);
        chk("t3_drain_grant", {30'b0, grant}, 32'd1);
        chk("t3_drain_busy", {31'b0, busy}, 32'd1);
        ok = 1'b1;
        repeat (500) begin
            @(negedge inclk);
            if (tx_on !== 1'b0 || grant !== 2'b01 || busy !== 1'b1) ok = 1'b0;
        end
        chk("t3_drain_hold", {31'b0, ok}, 32'd1);
        tx_machine_on = 1'b0;
        req0_on = 1'b1;
        @(negedge inclk);
        chk("t3_gap_grant", {30'b0, grant}, 32'd0);
        chk("t3_gap_busy", {31'b0, busy}, 32'd1);
        gap_n = 1; idle_n = 0; n = 0;
        while (grant == 2'b00 && n < 300) begin
            @(negedge inclk);
            n++;
            if (grant == 2'b00) begin
                if (busy) gap_n++;
                else idle_n++;
            end
        end
        chk("t3_gap_cycles", gap_n, 32'd64);
        chk("t3_idle_cycles", idle_n, 32'd1);
        chk("t3_regrant", {30'b0, grant}, 32'd1);
        finish_packet("t3");

        // Start timeout: transmitter never starts
        req1_on = 1'b1;
        @(negedge inclk);
        n_on = 0; early = 1'b0;
        while (tx_on === 1'b1 && n_on < 1100) begin
            if (timeout_err) early = 1'b1;
            n_on++;
            @(negedge inclk);
        end
        chk("t4_active_cycles", n_on, 32'd1024);
        chk("t4_early_err", {31'b0, early}, 32'd0);
        chk("t4_err", {31'b0, timeout_err}, 32'd1);
        chk("t4_grant", {30'b0, grant}, 32'd0);
        chk("t4_busy", {31'b0, busy}, 32'd1);
        req1_on = 1'b0;
        @(negedge inclk);
        chk("t4_err_pulse", {31'b0, timeout_err}, 32'd0);
        repeat (62) @(negedge inclk);
        chk("t4_gap_busy", {31'b0, busy}, 32'd1);
        @(negedge inclk);
        chk("t4_idle", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-ACTIVE
        req0_on = 1'b1;
        @(negedge inclk);
        chk("t5_tx_on", {31'b0, tx_on}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_tx_on", {31'b0, tx_on}, 32'd0);
        chk("t5_rst_grant", {30'b0, grant}, 32'd0);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge inclk);
        reset = 1'b0;
        #1;
        chk("t5_rel_tx_on", {31'b0, tx_on}, 32'd0);
        @(negedge inclk);
        chk("t5_grant", {30'b0, grant}, 32'd1);
        chk("t5_tx_on2", {31'b0, tx_on}, 32'd1);
        finish_packet("t5");

        // GAP_CYCLES = 0 instance: pulse ignored in GAP, held request granted
        reset = 1'b1;
        @(negedge inclk);
        reset = 1'b0;
        req1_on = 1'b1;
        @(negedge inclk);
        chk("t6_grant", {30'b0, g0_grant}, 32'd2);
        req1_on = 1'b0; tx_machine_on = 1'b1;
        @(negedge inclk);
        tx_machine_on = 1'b0;
        @(negedge inclk);
        chk("t6_gap_busy", {31'b0, g0_busy}, 32'd1);
        chk("t6_gap_grant", {30'b0, g0_grant}, 32'd0);
        req1_on = 1'b1;
        @(negedge inclk);
        req1_on = 1'b0;
        chk("t6_idle_busy", {31'b0, g0_busy}, 32'd0);
        chk("t6_idle_grant", {30'b0, g0_grant}, 32'd0);
        @(negedge inclk);
        chk("t6_nogrant", {30'b0, g0_grant}, 32'd0);
        chk("t6_nogrant_tx_on", {31'b0, g0_tx_on}, 32'd0);
        req1_on = 1'b1;
        @(negedge inclk);
        chk("t6_grant2", {30'b0, g0_grant}, 32'd2);
        req1_on = 1'b0; tx_machine_on = 1'b1;
        @(negedge inclk);
        tx_machine_on = 1'b0; req1_on = 1'b1;
        @(negedge inclk);
        chk("t6_gap2_grant", {30'b0, g0_grant}, 32'd0);
        chk("t6_gap2_busy", {31'b0, g0_busy}, 32'd1);
        @(negedge inclk);
        chk("t6_idle2_busy", {31'b0, g0_busy}, 32'd0);
        @(negedge inclk);
        chk("t6_held_grant", {30'b0, g0_grant}, 32'd2);
        chk("t6_held_tx_on", {31'b0, g0_tx_on}, 32'd1);
        req1_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
